// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample and slot widths, the stereo sample pair type and
// the 64-bit frame layout. Also used by the I2S slave receiver.
package i2s_pkg;

    localparam int SMPL_W     = 24;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int PAD_W      = SLOT_W - SMPL_W;
    localparam int SLOT_CNT_W = $clog2(FRAME_BITS);

    typedef struct packed {
        logic [SMPL_W-1:0] lft;
        logic [SMPL_W-1:0] rght;
    } stereo_smpl_t;

    typedef logic [FRAME_BITS-1:0] frame_t;

    // Each channel is left-justified in its 32-bit slot, padded with zeros.
    function automatic frame_t pack_frame(input stereo_smpl_t p);
        return {p.lft, {PAD_W{1'b0}}, p.rght, {PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock generator: divides clk by 2*SCLK_DIV and flags the cycle before each
// sclk edge so downstream registers can update on the very same clk edge.
module i2s_clk_gen #(
    parameter int SCLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic I2S_sclk,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int              CNT_W    = $clog2(SCLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Ticks are decoded from the pre-edge state: high in the cycle whose closing
    // edge moves sclk.
    assign fall_tick = w_wrap &  r_sclk;
    assign rise_tick = w_wrap & ~r_sclk;
    assign I2S_sclk  = r_sclk;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: generates sclk/ws and serialises 24-bit stereo pairs
// from a one-deep holding buffer. Define I2S_TX_UNDERRUN_ZERO_EN to send silence
// on underrun; otherwise the last transmitted pair is repeated.
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SMPL_W-1:0] lft_smpl,
    input  logic [SMPL_W-1:0] rght_smpl,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              I2S_sclk,
    output logic              I2S_ws,
    output logic              I2S_data,
    output logic              undrrun
);

    logic                  w_fall_tick;
    logic                  w_rise_tick;
    logic                  w_frame_start;
    logic                  w_accept;
    logic [SLOT_CNT_W-1:0] w_slot_next;
    stereo_smpl_t          w_fill;

    logic [SLOT_CNT_W-1:0] r_slot;
    logic                  r_ws;
    logic                  r_data;
    logic                  r_stage;
    frame_t                r_shift;
    stereo_smpl_t          r_buf;
    logic                  r_empty;
    logic                  r_undrrun;

    i2s_clk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .I2S_sclk  (I2S_sclk),
        .fall_tick (w_fall_tick),
        .rise_tick (w_rise_tick)
    );

    assign w_slot_next   = r_slot + SLOT_CNT_W'(1);
    assign w_frame_start = w_fall_tick & (&r_slot);
    assign w_accept      = smpl_vld & r_empty;

    // Frame start looks at r_empty before this cycle's accept, so a pair arriving
    // exactly at frame start waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf   <= '0;
            r_empty <= 1'b1;
        end else if (w_accept) begin
            r_buf   <= {lft_smpl, rght_smpl};
            r_empty <= 1'b0;
        end else if (w_frame_start && !r_empty) begin
            r_empty <= 1'b1;
        end
    end

`ifdef I2S_TX_UNDERRUN_ZERO_EN
    assign w_fill = '0;
`else
    stereo_smpl_t r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
        end else if (w_frame_start && !r_empty) begin
            r_last <= r_buf;
        end
    end

    assign w_fill = r_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot <= '1;
            r_ws   <= 1'b1;
        end else if (w_fall_tick) begin
            r_slot <= w_slot_next;
            r_ws   <= w_slot_next[SLOT_CNT_W-1];
        end
    end

    // The next bit is staged at mid-slot (sclk rise) and launched at the fall,
    // giving the one-bit lag behind ws; slot 0 always carries the last pad zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_stage   <= 1'b0;
            r_data    <= 1'b0;
            r_undrrun <= 1'b0;
        end else begin
            r_undrrun <= 1'b0;
            if (w_frame_start) begin
                r_data <= 1'b0;
                if (!r_empty) begin
                    r_shift <= pack_frame(r_buf);
                end else begin
                    r_shift   <= pack_frame(w_fill);
                    r_undrrun <= 1'b1;
                end
            end else if (w_fall_tick) begin
                r_data <= r_stage;
            end else if (w_rise_tick) begin
                r_stage <= r_shift[FRAME_BITS-1];
                r_shift <= r_shift << 1;
            end
        end
    end

    assign smpl_rdy = r_empty;
    assign I2S_ws   = r_ws;
    assign I2S_data = r_data;
    assign undrrun  = r_undrrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx: frame timing, serial layout, handshake,
// underrun fill (either build of I2S_TX_UNDERRUN_ZERO_EN), mid-frame reset, SCLK_DIV=2.
`timescale 1ns/1ps
module tb_i2s_master_tx;

`ifdef I2S_TX_UNDERRUN_ZERO_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif
    localparam logic [63:0] WS_EXP = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] lft_smpl, rght_smpl;
    logic        smpl_vld, smpl_rdy, I2S_sclk, I2S_ws, I2S_data, undrrun;

    logic        rst2;
    logic [23:0] lft2, rght2;
    logic        vld2, rdy2, sclk2, ws2, data2, und2;

    int total = 0;
    int bad   = 0;
    int edge_n, n_und, n_acc;
    bit auto_inc;

    logic [63:0] cap_d, cap_dm, cap_w, cap_rv, cap_sck;
    logic        cap_und0;

    always #10 clk = ~clk;

    i2s_master_tx #(.SCLK_DIV(16)) u_dut (
        .clk(clk), .rst(rst), .lft_smpl(lft_smpl), .rght_smpl(rght_smpl),
        .smpl_vld(smpl_vld), .smpl_rdy(smpl_rdy), .I2S_sclk(I2S_sclk),
        .I2S_ws(I2S_ws), .I2S_data(I2S_data), .undrrun(undrrun)
    );

    i2s_master_tx #(.SCLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst2), .lft_smpl(lft2), .rght_smpl(rght2),
        .smpl_vld(vld2), .smpl_rdy(rdy2), .I2S_sclk(sclk2),
        .I2S_ws(ws2), .I2S_data(data2), .undrrun(und2)
    );

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Layout: slot 0 = 0, slot k = frame bit [64-k]; vector bit [63-k] is slot k.
    function automatic logic [63:0] fexp(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 8'h00, r, 7'h00};
    endfunction

    task automatic cyc1();
        logic acc;
        acc = smpl_vld & smpl_rdy;
        @(posedge clk); #1;
        edge_n++;
        if (undrrun) n_und++;
        if (acc) begin
            n_acc++;
            if (auto_inc) begin
                lft_smpl  = lft_smpl + 24'd2;
                rght_smpl = rght_smpl + 24'd2;
            end else begin
                smpl_vld = 1'b0;
            end
        end
    endtask

    // Call 1ns after a frame-start edge; returns 1ns after the next one.
    task automatic capture_frame(input int end_vld);
        for (int c = 0; c < 2048; c++) begin
            if (c % 32 == 0) begin
                cap_d[63 - c/32]  = I2S_data;
                cap_w[63 - c/32]  = I2S_ws;
                cap_rv[63 - c/32] = smpl_rdy;
            end
            if (c % 32 == 16) begin
                cap_dm[63 - c/32]  = I2S_data;
                cap_sck[63 - c/32] = I2S_sclk;
            end
            if (c == 0) cap_und0 = undrrun;
            if (c == 2047 && end_vld >= 0) smpl_vld = (end_vld == 1);
            cyc1();
        end
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp_d, input logic exp_und);
        check({tag, ".data"},     cap_d,    exp_d);
        check({tag, ".data_mid"}, cap_dm,   exp_d);
        check({tag, ".ws"},       cap_w,    WS_EXP);
        check({tag, ".sclk_hi"},  cap_sck,  64'hFFFF_FFFF_FFFF_FFFF);
        check({tag, ".undrrun"},  cap_und0, exp_und);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".sclk"},  I2S_sclk, 1'b0);
        check({tag, ".ws"},    I2S_ws,   1'b1);
        check({tag, ".data"},  I2S_data, 1'b0);
        check({tag, ".und"},   undrrun,  1'b0);
        check({tag, ".rdy"},   smpl_rdy, 1'b1);
    endtask

    initial begin
        int first_u, second_u, sclk2_e2;
        logic data2_or;

        rst = 1'b1; rst2 = 1'b1; smpl_vld = 1'b0; auto_inc = 1'b0;
        lft_smpl = '0; rght_smpl = '0; lft2 = '0; rght2 = '0; vld2 = 1'b0;
        n_und = 0; n_acc = 0; edge_n = 0;

        // Reset and idle frame timing.
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0; edge_n = 0;
        for (int e = 1; e <= 31; e++) begin
            cyc1();
            if (e == 15) check("idle.sclk_e15", I2S_sclk, 1'b0);
            if (e == 16) check("idle.sclk_e16", I2S_sclk, 1'b1);
        end
        check("idle.ws_e31", I2S_ws, 1'b1);
        check("idle.und_e31", n_und, 0);
        cyc1();
        check("idle.sclk_e32", I2S_sclk, 1'b0);
        check("idle.ws_e32", I2S_ws, 1'b0);
        check("idle.und_e32", undrrun, 1'b1);

        capture_frame(-1);                       // F0 idle
        check_frame("F0", 64'h0, 1'b1);
        check("F1.und_e2080", undrrun, 1'b1);
        check("F1.edge", edge_n, 2080);
        check("F1.n_und", n_und, 2);

        // Single pair accepted during F1, sent in F2.
        lft_smpl = 24'hA5A5A5; rght_smpl = 24'h5A5A5A; smpl_vld = 1'b1;
        capture_frame(-1);                       // F1 underrun, no prior pair
        check_frame("F1", 64'h0, 1'b1);
        check("F1.rdy", cap_rv, 64'h8000_0000_0000_0000);
        check("F2.rdy_back", smpl_rdy, 1'b1);

        // Back-to-back pairs start here.
        auto_inc = 1'b1; lft_smpl = 24'h000001; rght_smpl = 24'h000002; smpl_vld = 1'b1;
        capture_frame(-1);                       // F2
        check_frame("F2", 64'h52D2_D280_2D2D_2D00, 1'b0);
        check("F2.left", cap_d[62:39], 24'hA5A5A5);
        check("F2.right", cap_d[30:7], 24'h5A5A5A);
        check("F2.pad_l", cap_d[38:31], 8'h00);
        check("F2.pad_r", cap_d[6:0], 7'h00);
        capture_frame(-1);                       // F3
        check_frame("F3", fexp(24'h000001, 24'h000002), 1'b0);
        check("F3.rdy", cap_rv, 64'h8000_0000_0000_0000);
        capture_frame(-1);                       // F4
        check_frame("F4", fexp(24'h000003, 24'h000004), 1'b0);
        capture_frame(-1);                       // F5
        check_frame("F5", fexp(24'h000005, 24'h000006), 1'b0);
        smpl_vld = 1'b0; auto_inc = 1'b0;
        check("b2b.n_acc", n_acc, 5);
        check("b2b.n_und", n_und, 2);

        // Pair presented exactly in the F7 frame-start cycle.
        lft_smpl = 24'h800000; rght_smpl = 24'h7FFFFF;
        capture_frame(1);                        // F6
        check_frame("F6", fexp(24'h000007, 24'h000008), 1'b0);
        check("F7.und", undrrun, 1'b1);
        check("F7.rdy", smpl_rdy, 1'b0);
        check("F7.n_acc", n_acc, 6);

        // Inputs must be ignored while the buffer is full.
        lft_smpl = 24'hDEADBE; rght_smpl = 24'hBEEF00; smpl_vld = 1'b1;
        capture_frame(0);                        // F7 underrun fill
        check_frame("F7", ZERO_FILL ? 64'h0 : fexp(24'h000007, 24'h000008), 1'b1);
        check("F8.rdy", smpl_rdy, 1'b1);
        capture_frame(-1);                       // F8 extreme pair
        check_frame("F8", fexp(24'h800000, 24'h7FFFFF), 1'b0);
        check("F8.msb_l", cap_d[62], 1'b1);
        check("F8.msb_r", cap_d[30], 1'b0);
        check("F8.left", cap_d[62:39], 24'h800000);
        check("F8.right", cap_d[30:7], 24'h7FFFFF);

        // Mid-frame reset at s=40 with the buffer full.
        lft_smpl = 24'h123456; rght_smpl = 24'h654321; smpl_vld = 1'b1;
        repeat (1296) cyc1();
        check("s40.ws", I2S_ws, 1'b1);
        check("s40.sclk", I2S_sclk, 1'b1);
        check("s40.rdy", smpl_rdy, 1'b0);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; edge_n = 0; n_und = 0;
        repeat (32) cyc1();
        check("post.rdy", smpl_rdy, 1'b1);
        capture_frame(-1);
        check_frame("post", 64'h0, 1'b1);

        // SCLK_DIV=2 instance: 256-clk frame period.
        @(posedge clk); #1;
        rst2 = 1'b0;
        first_u = -1; second_u = -1; sclk2_e2 = 0; data2_or = 1'b0;
        for (int e = 1; e <= 600; e++) begin
            @(posedge clk); #1;
            if (e == 2) sclk2_e2 = int'(sclk2);
            data2_or = data2_or | data2;
            if (und2) begin
                if (first_u < 0) first_u = e;
                else if (second_u < 0) second_u = e;
            end
        end
        check("div2.sclk_e2", sclk2_e2, 1);
        check("div2.first_und", first_u, 4);
        check("div2.period", second_u - first_u, 256);
        check("div2.data", data2_or, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_master_tx.md
# i2s_master_tx

I2S master transmitter: it generates `I2S_sclk` and `I2S_ws` from the system clock and serializes 24-bit left/right samples onto `I2S_data`. It is the far end of the I2S link that the equalizer's I2S slave receiver consumes. It serves as the audio source model in full-chip benches and as the I2S output stage for a future line-out path. Samples enter through a one-deep valid/ready holding buffer and are transmitted one stereo frame at a time.

## Interface
- `SCLK_DIV`, default 16: `clk` cycles per `I2S_sclk` half-period; minimum 2. The default gives a 1.5625 MHz sclk and about 24.4 kHz fs at 50 MHz.
- `clk` input, 1 bit: 50 MHz system clock; the only clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `lft_smpl` input, 24 bits: left sample, two's complement.
- `rght_smpl` input, 24 bits: right sample, two's complement.
- `smpl_vld` input, 1 bit: sample pair valid.
- `smpl_rdy` output, 1 bit: holding buffer empty; a pair is accepted on `smpl_vld & smpl_rdy`.
- `I2S_sclk` output, 1 bit: bit clock, registered.
- `I2S_ws` output, 1 bit: word select; 0 = left, 1 = right; registered.
- `I2S_data` output, 1 bit: serial data, MSB first; registered.
- `undrrun` output, 1 bit: one-`clk` pulse when a frame starts with the holding buffer empty.

## Operation
- Divider: `cnt` runs 0..`SCLK_DIV`-1 and wraps. `I2S_sclk` toggles on the clk edge where `cnt`==`SCLK_DIV`-1. `fall_tick` marks the cycle where sclk goes 1→0.
- Slot counter `s` is 6 bits, 0..63, and advances on every `fall_tick`, wrapping 63→0.
- `I2S_ws` = `s[5]`, so it changes only on sclk falling edges.
- Frame word is 64 bits: {lft, 8'h00, rght, 8'h00}.
- On the `fall_tick` where `s` goes 63→0 (frame start):
  - If the buffer is full: copy the buffer into the shifter, then mark the buffer empty.
  - Else: `undrrun` pulses for that cycle and the shifter is loaded with the underrun frame (see Configuration).
- Data lags ws by one bit, per standard I2S:
  - At s=0, `I2S_data` = 0 (the last padding bit of the previous frame).
  - At s=k, k = 1..63, `I2S_data` = frame bit [64-k].
  - Left MSB is therefore at s=1, left LSB at s=24, and s=25..32 carry zeros.
  - Right MSB is at s=33, right LSB at s=56, and s=57..63 carry zeros.
- Holding buffer handshake:
  - `smpl_rdy` = buffer empty.
  - Accept on `smpl_vld & smpl_rdy`, capturing both channels in the same cycle.
  - When accept and frame-start fall in the same cycle, transfer uses the pre-cycle buffer state. An empty buffer therefore gives an underrun for that frame, and the accepted pair is held for the next frame.
  - Inputs are ignored while `smpl_rdy`=0.

## Timing
- Reset values:
  - `I2S_sclk`=0, `I2S_ws`=1, `I2S_data`=0, `undrrun`=0, `smpl_rdy`=1.
  - `cnt`=0, `s`=63, buffer empty, shifter all zeros.
- First sclk rise is at clk edge `SCLK_DIV` after reset release. The first fall (frame start, s→0) is at edge 2·`SCLK_DIV`.
- Frame period is 128·`SCLK_DIV` clks (2048 at the default).
- Latency: a pair accepted before a frame-start edge appears as left MSB on `I2S_data` 2·`SCLK_DIV` clks after that edge.
- All outputs are registered. `I2S_data` and `I2S_ws` change only in the same cycle as the sclk 1→0 transition, so they are stable across the sclk rise.
- Asserting `rst` mid-frame returns all state to reset values immediately and discards the buffered pair.

## Configuration
- `I2S_TX_UNDERRUN_ZERO_EN` defined: the underrun frame is all zeros (silence).
- `I2S_TX_UNDERRUN_ZERO_EN` undefined: the underrun frame repeats the last transmitted pair. After reset with no prior pair, that is zeros.
- `undrrun` pulses in both builds.

## Structure
- Package `i2s_pkg`:
  - `SMPL_W`=24, `SLOT_W`=32, `FRAME_BITS`=64.
  - Typedef `stereo_smpl_t` = packed {lft, rght} of `SMPL_W` each.
  - Shared with the I2S slave receiver.
- Sub-module `i2s_clk_gen` (parameter `SCLK_DIV`; ports `clk`, `rst`, `I2S_sclk`, `fall_tick`, `rise_tick`).
- The top holds the slot counter, buffer, shifter and underrun logic.

## Test plan
- Reset, then idle with no `smpl_vld`:
  - First sclk fall is at clk 32.
  - `undrrun` pulses at clk 32 and every 2048 clks after.
  - `I2S_data` stays 0.
  - ws is low for 32 sclk periods and high for 32.
- Accept lft=24'hA5A5A5, rght=24'h5A5A5A before the first frame:
  - The slave-side decode of bits s=1..24 gives A5A5A5, and s=33..56 gives 5A5A5A.
  - s=25..32 and s=57..63 are 0.
  - `smpl_rdy` returns to 1 at the frame-start edge.
- Back-to-back pairs with `smpl_vld` held high and incrementing 24'h000001, 24'h000002, …: one pair is accepted per frame, none are dropped or duplicated, and `undrrun` never pulses.
- Present `smpl_vld` exactly in the frame-start cycle with the buffer empty:
  - `undrrun` pulses.
  - The current frame is zeros (ZERO_EN build) or the last pair repeated (default build).
  - The pair appears in the following frame.
- Extreme values lft=24'h800000, rght=24'h7FFFFF: the MSB arrives at s=1 and s=33 respectively, and the serial bits match the reconstructed values bit-exactly.
- Assert `rst` at s=40 with the buffer full:
  - Outputs return to reset values within the same clk.
  - After release, the first frame is an underrun frame (the buffered pair was discarded).
  - Then run with `SCLK_DIV`=2 and confirm the 256-clk frame period.
